// File: rtl/adder_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter_pkg
// Shared definitions for the round-robin adder arbiter:
//   - FSM state encoding (IDLE / EXEC / RESP)
//   - operand width of the shared adder
//   - packed operand bundle latched at grant time
// No ports (package).
// ---------------------------------------------------------------------------
package adder_rr_arbiter_pkg;

   localparam int OPW = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
      logic           cin;
   } opnd_t;

endpackage

// File: rtl/adder_rr_arbiter_adder32_cla.sv
// ---------------------------------------------------------------------------
// adder32_cla
// Registered 32-bit carry-lookahead adder. Carries are resolved per 4-bit
// group from group generate/propagate terms; sum and carry-out are captured
// on a rising edge while enabled and otherwise hold.
// Ports:
//   clk      clock
//   rst_n_i  synchronous active-low reset, clears sum_o / cout_o
//   en_i     capture enable
//   a_i, b_i operands (OPW bits)
//   cin_i    carry-in
//   sum_o    registered sum, (a+b+cin) mod 2^OPW
//   cout_o   registered carry-out
// ---------------------------------------------------------------------------
module adder32_cla
   import adder_rr_arbiter_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n_i,
   input  logic           en_i,
   input  logic [OPW-1:0] a_i,
   input  logic [OPW-1:0] b_i,
   input  logic           cin_i,
   output logic [OPW-1:0] sum_o,
   output logic           cout_o
);

   localparam int NGRP = OPW / 4;

   logic [OPW-1:0]  gen;
   logic [OPW-1:0]  prop;
   logic [NGRP-1:0] grp_g;
   logic [NGRP-1:0] grp_p;
   logic [OPW-1:0]  sum_d;
   logic            cout_d;
   logic            gcarry;
   logic            bcarry;

   always_comb begin
      gen   = a_i & b_i;
      prop  = a_i ^ b_i;
      grp_g = '0;
      grp_p = '0;
      for (int k = 0; k < NGRP; k++) begin
         grp_g[k] = gen[4*k+3]
                  | (prop[4*k+3] & gen[4*k+2])
                  | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                  | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
         grp_p[k] = &prop[4*k +: 4];
      end
   end

   // Group carries chain through the lookahead terms; bits inside a group
   // are derived from that group's carry-in.
   always_comb begin
      sum_d  = '0;
      gcarry = cin_i;
      bcarry = 1'b0;
      for (int k = 0; k < NGRP; k++) begin
         bcarry = gcarry;
         for (int j = 0; j < 4; j++) begin
            sum_d[4*k+j] = prop[4*k+j] ^ bcarry;
            bcarry       = gen[4*k+j] | (prop[4*k+j] & bcarry);
         end
         gcarry = grp_g[k] | (grp_p[k] & gcarry);
      end
      cout_d = gcarry;
   end

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         sum_o  <= '0;
         cout_o <= 1'b0;
      end else if (en_i) begin
         sum_o  <= sum_d;
         cout_o <= cout_d;
      end
   end

endmodule

// File: rtl/adder_rr_arbiter.sv
// ---------------------------------------------------------------------------
// adder_rr_arbiter
// Shares one registered 32-bit adder among NREQ requesters. A round-robin
// grant is issued combinationally in IDLE, operands are latched, the adder
// runs for one cycle in EXEC, and the result is presented in RESP until the
// consumer accepts it.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req_valid  per-requester request            [NREQ]
//   req_ready  per-requester accept (one-hot/0) [NREQ]
//   req_a      operand A, requester i at [32i+31:32i]
//   req_b      operand B, same packing
//   req_cin    per-requester carry-in          [NREQ]
//   rsp_valid  result available
//   rsp_ready  result accepted by consumer
//   rsp_id     owner of the result             [IDW]
//   rsp_sum    a+b+cin mod 2^32
//   rsp_cout   carry-out of a+b+cin
//   busy       high outside IDLE
// ---------------------------------------------------------------------------
module adder_rr_arbiter
   import adder_rr_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*OPW-1:0] req_a,
   input  logic [NREQ*OPW-1:0] req_b,
   input  logic [NREQ-1:0]     req_cin,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [OPW-1:0]      rsp_sum,
   output logic                rsp_cout,
   output logic                busy
);

   logic [1:0]     state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] gid_q;
   opnd_t          opnd_q;
   opnd_t          opnd_sel;

   logic           any_req;
   logic           found;
   logic           grant_en;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] cand;
   int             idx;

   logic           add_en;
   logic           add_rst_n;
   logic [OPW-1:0] add_sum;
   logic           add_cout;

   // Round-robin search: first requester at or after last_grant+1, wrapping.
   always_comb begin
      any_req   = |req_valid;
      found     = 1'b0;
      grant_idx = '0;
      idx       = 0;
      cand      = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(last_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IDW'(idx);
         if (!found && req_valid[cand]) begin
            found     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign grant_en  = (state_q == ST_IDLE) && any_req;
   assign req_ready = grant_en ? (NREQ'(1) << grant_idx) : '0;

   always_comb begin
      opnd_sel.a   = req_a[grant_idx*OPW +: OPW];
      opnd_sel.b   = req_b[grant_idx*OPW +: OPW];
      opnd_sel.cin = req_cin[grant_idx];
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d = ST_EXEC;
               last_d  = grant_idx;
            end
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= IDW'(NREQ - 1);
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Operand and owner capture at grant time; meaningful only while busy.
   always_ff @(posedge clk) begin
      if (grant_en) begin
         opnd_q <= opnd_sel;
         gid_q  <= grant_idx;
      end
   end

   // Adder clears together with the FSM so an aborted operation leaves no
   // stale result behind.
   assign add_en    = (state_q == ST_EXEC);
   assign add_rst_n = ~rst;

   adder32_cla u_adder (
      .clk     (clk),
      .rst_n_i (add_rst_n),
      .en_i    (add_en),
      .a_i     (opnd_q.a),
      .b_i     (opnd_q.b),
      .cin_i   (opnd_q.cin),
      .sum_o   (add_sum),
      .cout_o  (add_cout)
   );

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = rsp_valid ? gid_q    : '0;
   assign rsp_sum   = rsp_valid ? add_sum  : '0;
   assign rsp_cout  = rsp_valid ? add_cout : 1'b0;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder; legal range 2..8.
REQ-002 Parameter IDW, default 2, requester-ID width; SHALL equal clog2(NREQ).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_a  input  NREQ*32  operand A, requester i at bits [32i+31:32i].
REQ-008 req_b  input  NREQ*32  operand B, same packing.
REQ-009 req_cin  input  NREQ  carry-in per requester.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  result consumer accept.
REQ-012 rsp_id  output  IDW  index of the requester that owns the result.
REQ-013 rsp_sum  output  32  sum, a+b+cin mod 2^32.
REQ-014 rsp_cout  output  1  carry-out, bit 32 of a+b+cin.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; one operation in flight at most.
REQ-017 IDLE: if any req_valid high, grant exactly one requester g, assert req_ready[g] combinationally the same cycle, latch a, b, cin, g, go to EXEC; else stay.
REQ-018 Grant: round-robin, search starts at (last_grant+1) mod NREQ, wraps; last_grant updates only on a grant.
REQ-019 EXEC: drive adder enable=1 with latched operands for exactly one cycle, go to RESP.
REQ-020 RESP: rsp_valid=1, rsp_sum/rsp_cout from adder registered outputs, rsp_id=g; adder enable=0 so outputs hold.
REQ-021 RESP exits to IDLE only on the cycle rsp_valid and rsp_ready are both high; rsp_* stable while stalled.
REQ-022 Latency: grant cycle t, rsp_valid first high at t+2; peak throughput one operation per 3 cycles.
REQ-023 req_ready all zero outside IDLE; requests arriving in EXEC/RESP wait, no loss.
REQ-024 Requester obligation: req_valid and its operands held until req_ready; block does not check.
REQ-025 All NREQ requesting simultaneously: grants rotate, every requester served once in NREQ operations.
REQ-026 Overflow: 0xFFFFFFFF+0x00000001+0 SHALL yield sum 0x00000000, cout 1; no saturation.

Reset
REQ-027 rst high at a clock edge: state IDLE, last_grant = NREQ-1 (requester 0 highest priority first), req_ready 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0, busy 0.
REQ-028 rst asserted in EXEC or RESP aborts the operation; no response is ever issued for it.
REQ-029 Adder sub-module reset driven from the inverted rst, so its sum/cout clear in the same cycle.

Structure
REQ-030 Shared package holds state encoding (IDLE=0, EXEC=1, RESP=2) and the operand-width constant 32.
REQ-031 Exactly one sub-module: adder32_cla, instanced once, enable driven only by this block.
REQ-032 Round-robin priority select is in-module combinational logic; no second sub-module.

Verification
REQ-033 Single req0 a=0x00000005 b=0x00000003 cin=1 -> ready0 at t, rsp_valid t+2, sum 0x00000009, cout 0, id 0.
REQ-034 req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-035 req1 a=0xFFFFFFFF b=0x00000001 cin=0 -> sum 0x00000000, cout 1, id 1.
REQ-036 rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_sum stable, req_ready stays 0, req2 waiting granted the cycle after release.
REQ-037 rst pulsed in EXEC -> next cycle IDLE, rsp_valid 0, rsp_sum 0, next grant goes to requester 0.
REQ-038 req3 only, then req0 and req3 together -> second grant to 0 (pointer wrapped past 3).
